// File: rtl/hs32_pkg.sv
// Shared types and constants for the hs32 fetch stage.
package hs32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] HS32_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/hs32_fetch_if.sv
// Bundle of the fetch stage's memory-side and pipeline-side signals.
// master = fetch stage, slave = environment (instruction memory + pipeline).
interface hs32_fetch_if;
  import hs32_pkg::*;

  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic            mem_valid_i;
  logic [XLEN-1:0] mem_data_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] op_o;
  logic [XLEN-1:0] pc_o;

  modport master (
    input  flush_i, flush_pc_i, mem_ack_i, mem_valid_i, mem_data_i, ready_i,
    output mem_req_o, mem_addr_o, valid_o, op_o, pc_o
  );

  modport slave (
    output flush_i, flush_pc_i, mem_ack_i, mem_valid_i, mem_data_i, ready_i,
    input  mem_req_o, mem_addr_o, valid_o, op_o, pc_o
  );

endinterface

// File: rtl/hs32_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, op} entries. The head is read straight
// from the storage flops, so a word written on one edge is visible at the
// head from the next cycle on. clear empties the FIFO and wins over push/pop.
module hs32_fetch_fifo
  import hs32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch stage: issues sequential word fetches while credits
// allow, tags returning words with their PC, buffers them and hands them to
// the pipeline. A flush redirects fetch and discards everything older.
module hs32_fetch
  import hs32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = HS32_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input logic         clk,
  input logic         reset,
  hs32_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_reg, drop_next;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic [SW-1:0]   credit_sum;
  logic            fifo_valid;
  logic            mem_req;
  logic            fire;
  logic            resp;
  logic            resp_drop;
  logic            resp_keep;
  logic            pop;

  // Credits: every buffered word, outstanding request and pending discard
  // holds one FIFO slot, so the FIFO can never overflow.
  always_comb begin
    credit_sum = SW'(fifo_count) + SW'(inflight_reg) + SW'(drop_reg);
    mem_req    = !reset && !bus.flush_i && (credit_sum < SW'(DEPTH));
    fire       = mem_req && bus.mem_ack_i;
    resp       = bus.mem_valid_i && !reset;
    resp_drop  = resp && (drop_reg != '0);
    resp_keep  = resp && !resp_drop;
    fifo_valid = (fifo_count != '0);
    pop        = fifo_valid && bus.ready_i && !bus.flush_i;
    push_entry = '{pc: resp_pc_reg, op: bus.mem_data_i};
  end

  // Next-state for PCs and counters; a flush turns all in-flight requests
  // into pending discards and restarts both PCs at the aligned target.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    inflight_next = inflight_reg;
    drop_next     = drop_reg;
    if (bus.flush_i) begin
      fetch_pc_next = word_align(bus.flush_pc_i);
      resp_pc_next  = word_align(bus.flush_pc_i);
      inflight_next = '0;
      drop_next     = drop_reg + inflight_reg - CW'(resp);
    end else begin
      if (fire)      fetch_pc_next = fetch_pc_reg + 32'd4;
      if (resp_keep) resp_pc_next  = resp_pc_reg + 32'd4;
      inflight_next = inflight_reg + CW'(fire) - CW'(resp_keep);
      drop_next     = drop_reg - CW'(resp_drop);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.mem_valid_i && inflight_reg == '0 && drop_reg == '0));
    end
  end

  hs32_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .clear     (reset || bus.flush_i),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.mem_req_o  = mem_req;
  assign bus.mem_addr_o = fetch_pc_reg;
  assign bus.valid_o    = fifo_valid;
  assign bus.op_o       = fifo_valid ? fifo_head.op : '0;
  assign bus.pc_o       = fifo_valid ? fifo_head.pc : '0;

endmodule
